// File: rtl/sram_ctrl_pkg.sv
// Shared widths, chip-strobe levels, op codes and FSM encoding for the
// dual-chip asynchronous SRAM controller.
package sram_ctrl_pkg;

  localparam int RAM_BUS_W        = 32;
  localparam int RAM_ADDR_BUS_W   = 20;
  localparam int SRAM_WAIT_CYCLES = 2;
  localparam int WAIT_CNT_W       = 3;

  localparam logic CHIP_ENABLE  = 1'b0;
  localparam logic CHIP_DISABLE = 1'b1;

  localparam logic RAM_READ_OP  = 1'b0;
  localparam logic RAM_WRITE_OP = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_DONE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/sram_bank_port.sv
// Pin driver for one asynchronous SRAM chip: active-low strobes gated by the
// chip select, address gating and the tri-state data bus.
module sram_bank_port
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_BUS_W,
  parameter int DATA_W = RAM_BUS_W
) (
  input  logic              sel,
  input  logic              active,
  input  logic              rd_stb,
  input  logic              wr_stb,
  input  logic              drive,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we
);

  logic drive_en;

  assign drive_en = sel & drive;
  assign ram_data = drive_en ? wdata : {DATA_W{1'bz}};
  assign rdata    = ram_data;

  // An unselected or idle chip sees a parked address and all strobes released.
  assign ram_addr = (sel & active) ? addr : '0;
  assign ram_ce   = (sel & active) ? CHIP_ENABLE : CHIP_DISABLE;
  assign ram_oe   = (sel & rd_stb) ? CHIP_ENABLE : CHIP_DISABLE;
  assign ram_we   = (sel & wr_stb) ? CHIP_ENABLE : CHIP_DISABLE;

endmodule

// File: rtl/sram_ctrl.sv
// Word-access controller for the base/ext asynchronous SRAM pair: latches a
// ce/we request, sequences setup/strobe/hold and returns a one-cycle ready.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_BUS_W,
  parameter int DATA_W      = RAM_BUS_W,
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
  parameter int BANK_BIT    = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  inout  wire  [DATA_W-1:0] base_ram_data,
  output logic [ADDR_W-1:0] base_ram_addr,
  output logic              base_ram_ce,
  output logic              base_ram_oe,
  output logic              base_ram_we,
  inout  wire  [DATA_W-1:0] ext_ram_data,
  output logic [ADDR_W-1:0] ext_ram_addr,
  output logic              ext_ram_ce,
  output logic              ext_ram_oe,
  output logic              ext_ram_we
);

  state_t                state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  strobe_last;
  logic                  accept, active, rd_stb, wr_stb, drive;
  logic                  req_we, req_bank;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_data;
  logic [DATA_W-1:0]     base_rdata, ext_rdata;
  logic                  unused_addr;

  // Byte-lane bits and bits above the bank select alias onto the same word.
  assign unused_addr = ^addr_i;
  assign strobe_last = (wait_cnt == WAIT_CNT_W'(WAIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    active     = 1'b0;
    rd_stb     = 1'b0;
    wr_stb     = 1'b0;
    drive      = 1'b0;
    ready_o    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ce_i) begin
          accept     = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        active     = 1'b1;
        drive      = (req_we == RAM_WRITE_OP);
        state_next = ST_STROBE;
      end
      ST_STROBE: begin
        active = 1'b1;
        rd_stb = (req_we == RAM_READ_OP);
        wr_stb = (req_we == RAM_WRITE_OP);
        drive  = (req_we == RAM_WRITE_OP);
        if (strobe_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        // ce and write data stay put one more cycle as hold time.
        active     = 1'b1;
        drive      = (req_we == RAM_WRITE_OP);
        ready_o    = 1'b1;
        state_next = ce_i ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!ce_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                             wait_cnt <= '0;
    else if (rd_stb || wr_stb) begin
      if (strobe_last)                   wait_cnt <= '0;
      else                               wait_cnt <= wait_cnt + 1'b1;
    end else                             wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_we   <= RAM_READ_OP;
      req_bank <= 1'b0;
    end else if (accept) begin
      req_we   <= we_i;
      req_bank <= addr_i[BANK_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= addr_i[ADDR_W+1:2];
      req_data <= data_i;
    end
  end

  // Read data is captured on the last strobe edge while oe is still low.
  always_ff @(posedge clk) begin
    if (rst)                     data_o <= '0;
    else if (rd_stb && strobe_last) data_o <= req_bank ? ext_rdata : base_rdata;
  end

  sram_bank_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_base (
    .sel      (~req_bank),
    .active   (active),
    .rd_stb   (rd_stb),
    .wr_stb   (wr_stb),
    .drive    (drive),
    .addr     (req_addr),
    .wdata    (req_data),
    .rdata    (base_rdata),
    .ram_data (base_ram_data),
    .ram_addr (base_ram_addr),
    .ram_ce   (base_ram_ce),
    .ram_oe   (base_ram_oe),
    .ram_we   (base_ram_we)
  );

  sram_bank_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ext (
    .sel      (req_bank),
    .active   (active),
    .rd_stb   (rd_stb),
    .wr_stb   (wr_stb),
    .drive    (drive),
    .addr     (req_addr),
    .wdata    (req_data),
    .rdata    (ext_rdata),
    .ram_data (ext_ram_data),
    .ram_addr (ext_ram_addr),
    .ram_ce   (ext_ram_ce),
    .ram_oe   (ext_ram_oe),
    .ram_we   (ext_ram_we)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: behavioural SRAM models on both buses plus
// two extra instances with 1 and 7 wait states for latency checks.
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce_i, we_i;
  logic [31:0] addr_i, data_i;
  logic        ready_o;
  logic [31:0] data_o;
  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic        base_ram_ce, base_ram_oe, base_ram_we;
  logic        ext_ram_ce, ext_ram_oe, ext_ram_we;

  logic [31:0] base_mem [0:255];
  logic [31:0] ext_mem  [0:255];

  int total = 0;
  int bad   = 0;

  sram_ctrl dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .ready_o(ready_o), .data_o(data_o),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
    .base_ram_ce(base_ram_ce), .base_ram_oe(base_ram_oe), .base_ram_we(base_ram_we),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
    .ext_ram_ce(ext_ram_ce), .ext_ram_oe(ext_ram_oe), .ext_ram_we(ext_ram_we)
  );

  // Asynchronous SRAM models: drive on ce&oe low, latch on the rising edge of we.
  assign base_ram_data = (!base_ram_ce && !base_ram_oe) ? base_mem[base_ram_addr[7:0]] : 32'hzzzzzzzz;
  assign ext_ram_data  = (!ext_ram_ce && !ext_ram_oe) ? ext_mem[ext_ram_addr[7:0]] : 32'hzzzzzzzz;
  always @(posedge base_ram_we) if (!base_ram_ce) base_mem[base_ram_addr[7:0]] <= base_ram_data;
  always @(posedge ext_ram_we)  if (!ext_ram_ce)  ext_mem[ext_ram_addr[7:0]]  <= ext_ram_data;

  // Wait-state sweep instances: index 0 has WAIT_CYCLES=1, index 1 has 7.
  logic [1:0]  sw_ce, sw_ready, sw_bce, sw_boe, sw_bwe, sw_ece, sw_eoe, sw_ewe;
  wire  [31:0] w1_bdata, w1_edata, w7_bdata, w7_edata;
  logic [31:0] unused_dout0, unused_dout1;
  logic [19:0] unused_baddr0, unused_eaddr0, unused_baddr1, unused_eaddr1;

  assign w1_bdata = !sw_boe[0] ? 32'h1 : 32'hzzzzzzzz;
  assign w1_edata = !sw_eoe[0] ? 32'h1 : 32'hzzzzzzzz;
  assign w7_bdata = !sw_boe[1] ? 32'h7 : 32'hzzzzzzzz;
  assign w7_edata = !sw_eoe[1] ? 32'h7 : 32'hzzzzzzzz;

  sram_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .ce_i(sw_ce[0]), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .ready_o(sw_ready[0]), .data_o(unused_dout0),
    .base_ram_data(w1_bdata), .base_ram_addr(unused_baddr0),
    .base_ram_ce(sw_bce[0]), .base_ram_oe(sw_boe[0]), .base_ram_we(sw_bwe[0]),
    .ext_ram_data(w1_edata), .ext_ram_addr(unused_eaddr0),
    .ext_ram_ce(sw_ece[0]), .ext_ram_oe(sw_eoe[0]), .ext_ram_we(sw_ewe[0])
  );

  sram_ctrl #(.WAIT_CYCLES(7)) u_w7 (
    .clk(clk), .rst(rst), .ce_i(sw_ce[1]), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .ready_o(sw_ready[1]), .data_o(unused_dout1),
    .base_ram_data(w7_bdata), .base_ram_addr(unused_baddr1),
    .base_ram_ce(sw_bce[1]), .base_ram_oe(sw_boe[1]), .base_ram_we(sw_bwe[1]),
    .ext_ram_data(w7_edata), .ext_ram_addr(unused_eaddr1),
    .ext_ram_ce(sw_ece[1]), .ext_ram_oe(sw_eoe[1]), .ext_ram_we(sw_ewe[1])
  );

  // oe and we must never be low together on any chip of any instance.
  always @(negedge clk) begin
    if ((!base_ram_oe && !base_ram_we) || (!ext_ram_oe && !ext_ram_we) ||
        (|(~sw_boe & ~sw_bwe)) || (|(~sw_eoe & ~sw_ewe))) begin
      bad++;
      $display("FAIL oe_we_overlap at %0t: base oe/we=%b%b ext oe/we=%b%b", $time,
               base_ram_oe, base_ram_we, ext_ram_oe, ext_ram_we);
    end
  end

  // Results of the last run_access call.
  int          r_ready_cyc, r_rdy_cnt;
  int          r_base_ce_lo, r_base_oe_lo, r_base_we_lo, r_base_drv;
  int          r_ext_ce_lo, r_ext_oe_lo, r_ext_we_lo, r_ext_drv;
  logic [19:0] r_base_addr, r_ext_addr;
  logic [31:0] r_bus;
  bit          r_addr_changed;

  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input int hold, input int chg_cycle, input logic [31:0] chg_addr);
    int  stop_at;
    bit  base_seen, ext_seen;
    stop_at = 0; base_seen = 0; ext_seen = 0;
    r_ready_cyc = -1; r_rdy_cnt = 0; r_addr_changed = 0;
    r_base_ce_lo = 0; r_base_oe_lo = 0; r_base_we_lo = 0; r_base_drv = 0;
    r_ext_ce_lo = 0; r_ext_oe_lo = 0; r_ext_we_lo = 0; r_ext_drv = 0;
    r_base_addr = '0; r_ext_addr = '0; r_bus = '0;
    we_i = we; addr_i = addr; data_i = data; ce_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == chg_cycle) addr_i = chg_addr;
      if (!base_ram_ce) begin
        r_base_ce_lo++;
        if (base_seen && base_ram_addr != r_base_addr) r_addr_changed = 1;
        r_base_addr = base_ram_addr; base_seen = 1;
      end
      if (!ext_ram_ce) begin
        r_ext_ce_lo++;
        if (ext_seen && ext_ram_addr != r_ext_addr) r_addr_changed = 1;
        r_ext_addr = ext_ram_addr; ext_seen = 1;
      end
      if (!base_ram_oe) r_base_oe_lo++;
      if (!ext_ram_oe)  r_ext_oe_lo++;
      if (!base_ram_we) begin r_base_we_lo++; r_bus = base_ram_data; end
      if (!ext_ram_we)  begin r_ext_we_lo++;  r_bus = ext_ram_data;  end
      if (dut.u_base.drive_en) r_base_drv++;
      if (dut.u_ext.drive_en)  r_ext_drv++;
      if (ready_o) r_rdy_cnt++;
      if (ready_o && r_ready_cyc < 0) begin r_ready_cyc = k; stop_at = k + hold; end
      if (r_ready_cyc >= 0 && k == stop_at) break;
    end
    ce_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0; sw_ce = '0;
    repeat (3) @(negedge clk);
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
    total++; if ({base_ram_ce, base_ram_oe, base_ram_we, ext_ram_ce, ext_ram_oe, ext_ram_we} !== 6'b111111) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=111111",
        {base_ram_ce, base_ram_oe, base_ram_we, ext_ram_ce, ext_ram_oe, ext_ram_we}); end
    total++; if ({base_ram_addr, ext_ram_addr} !== 40'h0) begin
      bad++; $display("FAIL reset_addr got=%h/%h exp=0/0", base_ram_addr, ext_ram_addr); end
    total++; if ({dut.u_base.drive_en, dut.u_ext.drive_en} !== 2'b00) begin
      bad++; $display("FAIL reset_bus_drive got=%b%b exp=00", dut.u_base.drive_en, dut.u_ext.drive_en); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read_base();
    run_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, '0);
    total++; if (r_ready_cyc != 4) begin bad++; $display("FAIL wr_latency got=%0d exp=4", r_ready_cyc); end
    total++; if (r_base_addr !== 20'h00004) begin bad++; $display("FAIL wr_addr got=%h exp=00004", r_base_addr); end
    total++; if (r_base_we_lo != 2 || r_base_oe_lo != 0) begin
      bad++; $display("FAIL wr_strobes we_lo=%0d oe_lo=%0d exp=2/0", r_base_we_lo, r_base_oe_lo); end
    total++; if (r_base_drv != 4) begin bad++; $display("FAIL wr_drive_cycles got=%0d exp=4", r_base_drv); end
    total++; if (r_bus !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_bus got=%h exp=deadbeef", r_bus); end
    total++; if (r_ext_ce_lo + r_ext_oe_lo + r_ext_we_lo + r_ext_drv != 0) begin
      bad++; $display("FAIL wr_ext_quiet ce=%0d oe=%0d we=%0d drv=%0d exp=0", r_ext_ce_lo, r_ext_oe_lo, r_ext_we_lo, r_ext_drv); end
    total++; if (data_o !== 32'h0) begin bad++; $display("FAIL wr_data_o_kept got=%h exp=0", data_o); end
    total++; if (base_mem[4] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_mem got=%h exp=deadbeef", base_mem[4]); end
    run_access(1'b0, 32'h0000_0010, 32'h0, 0, 0, '0);
    total++; if (r_ready_cyc != 4) begin bad++; $display("FAIL rd_latency got=%0d exp=4", r_ready_cyc); end
    total++; if (r_base_oe_lo != 2 || r_base_we_lo != 0 || r_base_drv != 0) begin
      bad++; $display("FAIL rd_strobes oe_lo=%0d we_lo=%0d drv=%0d exp=2/0/0", r_base_oe_lo, r_base_we_lo, r_base_drv); end
    total++; if (data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", data_o); end
  endtask

  task automatic test_bank_select();
    run_access(1'b1, 32'h0000_0008, 32'hAAAA_AAAA, 0, 0, '0);
    run_access(1'b1, 32'h0040_0008, 32'h1234_5678, 0, 0, '0);
    total++; if (r_ext_addr !== 20'h00002) begin bad++; $display("FAIL bank_ext_addr got=%h exp=00002", r_ext_addr); end
    total++; if (r_ext_we_lo != 2) begin bad++; $display("FAIL bank_ext_we got=%0d exp=2", r_ext_we_lo); end
    total++; if (r_base_ce_lo + r_base_we_lo + r_base_drv != 0) begin
      bad++; $display("FAIL bank_base_quiet ce=%0d we=%0d drv=%0d exp=0", r_base_ce_lo, r_base_we_lo, r_base_drv); end
    total++; if (ext_mem[2] !== 32'h1234_5678) begin bad++; $display("FAIL bank_ext_mem got=%h exp=12345678", ext_mem[2]); end
    total++; if (base_mem[2] !== 32'hAAAA_AAAA) begin bad++; $display("FAIL bank_base_mem got=%h exp=aaaaaaaa", base_mem[2]); end
    run_access(1'b0, 32'h0000_0008, 32'h0, 0, 0, '0);
    total++; if (data_o !== 32'hAAAA_AAAA) begin bad++; $display("FAIL bank_base_read got=%h exp=aaaaaaaa", data_o); end
    run_access(1'b0, 32'h8040_000B, 32'h0, 0, 0, '0);
    total++; if (data_o !== 32'h1234_5678 || r_ext_addr !== 20'h00002) begin
      bad++; $display("FAIL bank_alias_read got=%h@%h exp=12345678@00002", data_o, r_ext_addr); end
  endtask

  task automatic test_sustained_ce();
    run_access(1'b0, 32'h0000_0010, 32'h0, 10, 0, '0);
    total++; if (r_rdy_cnt != 1) begin bad++; $display("FAIL hold_ready_count got=%0d exp=1", r_rdy_cnt); end
    total++; if (r_base_ce_lo != 4 || r_base_oe_lo != 2) begin
      bad++; $display("FAIL hold_single_strobe ce_lo=%0d oe_lo=%0d exp=4/2", r_base_ce_lo, r_base_oe_lo); end
    run_access(1'b0, 32'h0000_0008, 32'h0, 0, 0, '0);
    total++; if (r_ready_cyc != 4 || data_o !== 32'hAAAA_AAAA) begin
      bad++; $display("FAIL hold_rearm got=%0d/%h exp=4/aaaaaaaa", r_ready_cyc, data_o); end
  endtask

  task automatic test_mid_access_change();
    run_access(1'b1, 32'h0000_0020, 32'h5555_5555, 0, 0, '0);
    run_access(1'b0, 32'h0000_0010, 32'h0, 0, 2, 32'h0000_0020);
    total++; if (r_base_addr !== 20'h00004 || r_addr_changed) begin
      bad++; $display("FAIL midchg_addr got=%h changed=%0d exp=00004/0", r_base_addr, r_addr_changed); end
    total++; if (data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL midchg_data got=%h exp=deadbeef", data_o); end
  endtask

  task automatic test_reset_mid_write();
    int rdy;
    rdy = 0;
    we_i = 1'b1; addr_i = 32'h0000_0030; data_i = 32'hCAFE_F00D; ce_i = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (base_ram_we !== 1'b0) begin bad++; $display("FAIL rstmid_in_strobe we=%b exp=0", base_ram_we); end
    rst = 1'b1; ce_i = 1'b0;
    @(negedge clk);
    total++; if ({base_ram_ce, base_ram_oe, base_ram_we, ext_ram_ce, ext_ram_oe, ext_ram_we} !== 6'b111111) begin
      bad++; $display("FAIL rstmid_ctrl got=%b exp=111111",
        {base_ram_ce, base_ram_oe, base_ram_we, ext_ram_ce, ext_ram_oe, ext_ram_we}); end
    total++; if (dut.u_base.drive_en !== 1'b0) begin bad++; $display("FAIL rstmid_bus got=%b exp=0", dut.u_base.drive_en); end
    total++; if (data_o !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", data_o); end
    if (ready_o) rdy++;
    rst = 1'b0;
    repeat (10) begin @(negedge clk); if (ready_o) rdy++; end
    total++; if (rdy != 0) begin bad++; $display("FAIL rstmid_no_ready got=%0d exp=0", rdy); end
  endtask

  task automatic test_wait_sweep();
    for (int i = 0; i < 2; i++) begin
      for (int op = 0; op < 2; op++) begin
        int w, rc, oe_lo, we_lo;
        w = (i == 0) ? 1 : 7;
        rc = -1; oe_lo = 0; we_lo = 0;
        we_i = (op == 1); addr_i = 32'h0000_0010; data_i = 32'h0BAD_F00D;
        sw_ce[i] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
          @(negedge clk);
          if (!sw_boe[i]) oe_lo++;
          if (!sw_bwe[i]) we_lo++;
          if (sw_ready[i]) begin rc = k; break; end
        end
        sw_ce[i] = 1'b0;
        @(negedge clk);
        total++; if (rc != w + 2) begin bad++; $display("FAIL sweep_latency w=%0d op=%0d got=%0d exp=%0d", w, op, rc, w + 2); end
        total++; if ((op == 1 ? we_lo : oe_lo) != w || (op == 1 ? oe_lo : we_lo) != 0) begin
          bad++; $display("FAIL sweep_strobe w=%0d op=%0d oe_lo=%0d we_lo=%0d exp=%0d", w, op, oe_lo, we_lo, w); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read_base();
    test_bank_select();
    test_sustained_ce();
    test_mid_access_change();
    test_reset_mid_write();
    test_wait_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
